// File: rtl/reg_file_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// reg_file_ctrl_fsm
//
// Multi-cycle control unit for the simple processor. It latches one
// instruction at a time, decodes it, and sequences FETCH/DECODE/EXEC/MEM/WB.
// It drives the 8x8 register file (read/write addresses, one-cycle write
// strobe), the ALU controls and the data-memory request/BUSYWAIT handshake.
// Every output is a flop.
//
// Instruction fields: opcode[31:24], dest[18:16], src1[10:8], src2/imm[7:0].
//
// Ports
//   CLK           in   clock, rising edge
//   RESET         in   synchronous, active-high reset
//   INSTRUCTION   in   instruction word from instruction memory
//   INSTR_VALID   in   INSTRUCTION is valid this cycle
//   ZERO          in   ALU zero flag (sampled at the end of EXEC for beq)
//   BUSYWAIT      in   data memory busy
//   READREG1      out  register-file read address 1 (src1)
//   READREG2      out  register-file read address 2 (src2)
//   WRITEREG      out  register-file write address (dest)
//   WRITEENABLE   out  register-file write strobe (WB only, one cycle)
//   IMM           out  immediate / offset
//   IMM_SEL       out  ALU operand 2: 1 = IMM, 0 = REGOUT2
//   SUB_SEL       out  negate ALU operand 2
//   ALUOP         out  000 FWD, 001 ADD, 010 AND, 011 OR
//   MEM_READ      out  data memory read request
//   MEM_WRITE     out  data memory write request
//   WB_SEL        out  write-back source: 0 = ALU, 1 = memory
//   PC_ADVANCE    out  one-cycle PC update pulse
//   JUMP          out  qualifies PC_ADVANCE: jump
//   BRANCH_TAKEN  out  qualifies PC_ADVANCE: branch taken
//   ILLEGAL       out  sticky: illegal opcode or memory abort
//
// Build option
//   MEM_TIMEOUT_EN  when defined, a MEM access still busy after MEM_TIMEOUT
//                   cycles is aborted: the request drops, the FSM halts and
//                   ILLEGAL is set. When undefined, MEM waits indefinitely.
// -----------------------------------------------------------------------------
module reg_file_ctrl_fsm #(
   parameter int unsigned INSTR_W     = 32,
   parameter int unsigned REG_AW      = 3,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [INSTR_W-1:0] INSTRUCTION,
   input  logic               INSTR_VALID,
   input  logic               ZERO,
   input  logic               BUSYWAIT,
   output logic [REG_AW-1:0]  READREG1,
   output logic [REG_AW-1:0]  READREG2,
   output logic [REG_AW-1:0]  WRITEREG,
   output logic               WRITEENABLE,
   output logic [7:0]         IMM,
   output logic               IMM_SEL,
   output logic               SUB_SEL,
   output logic [2:0]         ALUOP,
   output logic               MEM_READ,
   output logic               MEM_WRITE,
   output logic               WB_SEL,
   output logic               PC_ADVANCE,
   output logic               JUMP,
   output logic               BRANCH_TAKEN,
   output logic               ILLEGAL
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd5
   } state_e;

   localparam logic [7:0] OpLoadi = 8'h00;
   localparam logic [7:0] OpMov   = 8'h01;
   localparam logic [7:0] OpAdd   = 8'h02;
   localparam logic [7:0] OpSub   = 8'h03;
   localparam logic [7:0] OpAnd   = 8'h04;
   localparam logic [7:0] OpOr    = 8'h05;
   localparam logic [7:0] OpJ     = 8'h06;
   localparam logic [7:0] OpBeq   = 8'h07;
   localparam logic [7:0] OpLwd   = 8'h08;
   localparam logic [7:0] OpLwi   = 8'h09;
   localparam logic [7:0] OpSwd   = 8'h0A;
   localparam logic [7:0] OpSwi   = 8'h0B;

   localparam logic [2:0] AluFwd = 3'b000;
   localparam logic [2:0] AluAdd = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;

   state_e              state_q, state_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic [REG_AW-1:0]   readreg1_q, readreg1_d;
   logic [REG_AW-1:0]   readreg2_q, readreg2_d;
   logic [REG_AW-1:0]   writereg_q, writereg_d;
   logic [7:0]          imm_q, imm_d;
   logic                imm_sel_q, imm_sel_d;
   logic                sub_sel_q, sub_sel_d;
   logic [2:0]          aluop_q, aluop_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic                wb_sel_q, wb_sel_d;
   logic                write_enable_q, write_enable_d;
   logic                pc_advance_q, pc_advance_d;
   logic                jump_q, jump_d;
   logic                branch_taken_q, branch_taken_d;
   logic                illegal_q, illegal_d;
   // High only in the first MEM cycle, where BUSYWAIT is not yet meaningful.
   logic                mem_first_q, mem_first_d;

   logic [7:0]          opcode;
   logic                is_load;
   logic                is_store;
   // Not every IR bit is a decoded field.
   logic                unused_ir;

   assign opcode    = ir_q[31:24];
   assign is_load   = (opcode == OpLwd) || (opcode == OpLwi);
   assign is_store  = (opcode == OpSwd) || (opcode == OpSwi);
   assign unused_ir = ^ir_q;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] MemLast = 8'(MEM_TIMEOUT - 1);

   // Number of completed MEM cycles; zero in the first MEM cycle.
   logic [7:0] mem_cnt_q, mem_cnt_d;
   logic       mem_timeout;

   assign mem_timeout = (mem_cnt_q == MemLast);
`endif

   always_comb begin
      state_d        = state_q;
      ir_d           = ir_q;
      readreg1_d     = readreg1_q;
      readreg2_d     = readreg2_q;
      writereg_d     = writereg_q;
      imm_d          = imm_q;
      illegal_d      = illegal_q;
      // Control strobes are pulses: low unless the next state asks for them.
      imm_sel_d      = 1'b0;
      sub_sel_d      = 1'b0;
      aluop_d        = AluFwd;
      mem_read_d     = 1'b0;
      mem_write_d    = 1'b0;
      wb_sel_d       = 1'b0;
      write_enable_d = 1'b0;
      pc_advance_d   = 1'b0;
      jump_d         = 1'b0;
      branch_taken_d = 1'b0;
      mem_first_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
      mem_cnt_d      = '0;
`endif

      unique case (state_q)
         StFetch: begin
            if (INSTR_VALID) begin
               ir_d    = INSTRUCTION;
               state_d = StDecode;
            end
         end

         // Outputs registered here are what the datapath sees during EXEC.
         StDecode: begin
            readreg1_d = ir_q[8 +: REG_AW];
            readreg2_d = ir_q[0 +: REG_AW];
            writereg_d = ir_q[16 +: REG_AW];
            imm_d      = ir_q[7:0];
            state_d    = StExec;
            case (opcode)
               OpLoadi: imm_sel_d = 1'b1;
               OpMov:   aluop_d   = AluFwd;
               OpAdd:   aluop_d   = AluAdd;
               OpSub: begin
                  aluop_d   = AluAdd;
                  sub_sel_d = 1'b1;
               end
               OpAnd:   aluop_d   = AluAnd;
               OpOr:    aluop_d   = AluOr;
               OpJ: begin
                  pc_advance_d = 1'b1;
                  jump_d       = 1'b1;
               end
               OpBeq: begin
                  aluop_d   = AluAdd;
                  sub_sel_d = 1'b1;
               end
               OpLwd, OpSwd: aluop_d = AluFwd;
               OpLwi, OpSwi: imm_sel_d = 1'b1;
               default: begin
                  state_d   = StHalt;
                  illegal_d = 1'b1;
               end
            endcase
         end

         StExec: begin
            case (opcode)
               OpJ:   state_d = StFetch;
               OpBeq: begin
                  pc_advance_d   = 1'b1;
                  branch_taken_d = ZERO;
                  state_d        = StFetch;
               end
               OpLwd, OpLwi: begin
                  mem_read_d  = 1'b1;
                  mem_first_d = 1'b1;
                  state_d     = StMem;
               end
               OpSwd, OpSwi: begin
                  mem_write_d = 1'b1;
                  mem_first_d = 1'b1;
                  state_d     = StMem;
               end
               default: begin
                  write_enable_d = 1'b1;
                  pc_advance_d   = 1'b1;
                  state_d        = StWb;
               end
            endcase
         end

         StMem: begin
            if (!mem_first_q && !BUSYWAIT) begin
               // Loads pulse PC_ADVANCE in WB, stores right after MEM.
               pc_advance_d = 1'b1;
               if (is_load) begin
                  write_enable_d = 1'b1;
                  wb_sel_d       = 1'b1;
                  state_d        = StWb;
               end else begin
                  state_d = StFetch;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (BUSYWAIT && mem_timeout) begin
               state_d   = StHalt;
               illegal_d = 1'b1;
            end
`endif
            else begin
               mem_read_d  = is_load;
               mem_write_d = is_store;
`ifdef MEM_TIMEOUT_EN
               mem_cnt_d   = mem_cnt_q + 8'd1;
`endif
            end
         end

         StWb: state_d = StFetch;

         // Only RESET leaves HALT.
         StHalt: state_d = StHalt;

         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q        <= StFetch;
         ir_q           <= '0;
         readreg1_q     <= '0;
         readreg2_q     <= '0;
         writereg_q     <= '0;
         imm_q          <= '0;
         imm_sel_q      <= 1'b0;
         sub_sel_q      <= 1'b0;
         aluop_q        <= AluFwd;
         mem_read_q     <= 1'b0;
         mem_write_q    <= 1'b0;
         wb_sel_q       <= 1'b0;
         write_enable_q <= 1'b0;
         pc_advance_q   <= 1'b0;
         jump_q         <= 1'b0;
         branch_taken_q <= 1'b0;
         illegal_q      <= 1'b0;
         mem_first_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         ir_q           <= ir_d;
         readreg1_q     <= readreg1_d;
         readreg2_q     <= readreg2_d;
         writereg_q     <= writereg_d;
         imm_q          <= imm_d;
         imm_sel_q      <= imm_sel_d;
         sub_sel_q      <= sub_sel_d;
         aluop_q        <= aluop_d;
         mem_read_q     <= mem_read_d;
         mem_write_q    <= mem_write_d;
         wb_sel_q       <= wb_sel_d;
         write_enable_q <= write_enable_d;
         pc_advance_q   <= pc_advance_d;
         jump_q         <= jump_d;
         branch_taken_q <= branch_taken_d;
         illegal_q      <= illegal_d;
         mem_first_q    <= mem_first_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         mem_cnt_q <= '0;
      end else begin
         mem_cnt_q <= mem_cnt_d;
      end
   end
`endif

   assign READREG1     = readreg1_q;
   assign READREG2     = readreg2_q;
   assign WRITEREG     = writereg_q;
   assign WRITEENABLE  = write_enable_q;
   assign IMM          = imm_q;
   assign IMM_SEL      = imm_sel_q;
   assign SUB_SEL      = sub_sel_q;
   assign ALUOP        = aluop_q;
   assign MEM_READ     = mem_read_q;
   assign MEM_WRITE    = mem_write_q;
   assign WB_SEL       = wb_sel_q;
   assign PC_ADVANCE   = pc_advance_q;
   assign JUMP         = jump_q;
   assign BRANCH_TAKEN = branch_taken_q;
   assign ILLEGAL      = illegal_q;

endmodule
